axi_lite_master: RTL and testbench

- Initiator end of the team's AXI-lite-style memory bus; drives the same five-channel interface (3-bit bresp/rresp) that the memory-side responders accept.
- Converts a single-beat load/store request from the core (IFU/LSU side) into one bus transaction and returns the data or status.
- Only one transaction is outstanding at a time; there is no reordering and no bursts.

---
 rtl/axi_lite_master.sv | 186 ++++++++++++++++++
 tb/tb_axi_lite_master.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite initiator: turns one core load/store into one bus transaction.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_lite_master #(
  parameter int unsigned DATA_LEN    = 32,
  parameter int unsigned STORB_LEN   = 4,
  parameter int unsigned ADDR_LEN    = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wen,
  input  logic [ADDR_LEN-1:0]  req_addr,
  input  logic [DATA_LEN-1:0]  req_wdata,
  input  logic [STORB_LEN-1:0] req_wmask,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_LEN-1:0]  resp_rdata,
  output logic                 resp_err,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [ADDR_LEN-1:0]  waddr,
  output logic                 wvalid,
  input  logic                 wready,
  output logic [DATA_LEN-1:0]  wdata,
  output logic [STORB_LEN-1:0] wstrob,
  input  logic                 bvalid,
  output logic                 bready,
  input  logic [2:0]           bresp,
  output logic                 arvalid,
  input  logic                 arready,
  output logic [ADDR_LEN-1:0]  raddr,
  input  logic                 rvalid,
  output logic                 rready,
  input  logic [DATA_LEN-1:0]  rdata,
  input  logic [2:0]           rresp,
  output logic                 timeout
);

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW_W,
    B,
    RESP
  } state_t;

  state_t              state;
  logic [ADDR_LEN-1:0] addr_q;
  logic                aw_done;
  logic                w_done;
  logic                aw_fire;
  logic                w_fire;
  logic                aw_all;
  logic                w_all;

  assign waddr   = addr_q;
  assign raddr   = addr_q;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign aw_all  = aw_done | aw_fire;
  assign w_all   = w_done | w_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      addr_q     <= '0;
      wdata      <= '0;
      wstrob     <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            addr_q    <= req_addr;
            wdata     <= req_wdata;
            wstrob    <= req_wmask;
            req_ready <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (req_wen) begin
              state   <= AW_W;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= AR;
              arvalid <= 1'b1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            rready     <= 1'b0;
            resp_rdata <= rdata;
            resp_err   <= |rresp;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        AW_W: begin
          // each channel retires on its own; B waits until both are done
          if (aw_fire) begin
            aw_done <= 1'b1;
            awvalid <= 1'b0;
          end
          if (w_fire) begin
            w_done <= 1'b1;
            wvalid <= 1'b0;
          end
          if (aw_all && w_all) begin
            bready <= 1'b1;
            state  <= B;
          end
        end
        B: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= |bresp;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT_CYC);

  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             busy;
  logic             to_q;

  assign cnt_inc = {1'b0, to_cnt} + (CNT_W + 1)'(1);
  assign busy    = (state == AR) || (state == R) || (state == AW_W) || (state == B);
  assign timeout = to_q;

  // Counter saturates at the limit; the flag only ever sets until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else if (busy) begin
      if (cnt_inc <= TO_LIM) to_cnt <= cnt_inc[CNT_W-1:0];
      if (cnt_inc >= TO_LIM) to_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0 & (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
module tb_axi_lite_master;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic [3:0]  wstrob;
  logic [2:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready, timeout;

  axi_lite_master #(
    .DATA_LEN(32), .STORB_LEN(4), .ADDR_LEN(32), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .waddr(waddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrob(wstrob),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .raddr(raddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .timeout(timeout)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_wmask;
  logic        exp_err;
  logic        exp_timeout;
  logic        txn_active, resp_due, chk_en;
  int          cyc_n, t0, busy_n, last_busy;
  int          ar_cyc, aw_cyc, w_cyc, ar_hs, aw_hs, w_hs, resp_cyc, first_resp_rel;
  logic        p_ar, p_arr, p_aw, p_awr, p_w, p_wr;

  task automatic fail(input string nm, input logic [63:0] act, input logic [63:0] exp);
    bad++;
    $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc_n = 0;
    forever begin
      @(posedge clk);
      cyc_n++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (TO_EN && last_busy >= 16) exp_timeout = 1'b1;
        if (txn_active) begin
          busy_n++;
          last_busy = busy_n;
        end else begin
          last_busy = 0;
        end
        total++;
        if (timeout !== exp_timeout) fail("timeout", timeout, exp_timeout);
        total++;
        if (req_ready !== !(txn_active || resp_due)) fail("req_ready", req_ready, !(txn_active || resp_due));
        total++;
        if (resp_valid !== resp_due) fail("resp_valid", resp_valid, resp_due);
        if (resp_valid) begin
          total++;
          if (resp_rdata !== exp_rdata) fail("resp_rdata", resp_rdata, exp_rdata);
          total++;
          if (resp_err !== exp_err) fail("resp_err", resp_err, exp_err);
          resp_cyc++;
          if (first_resp_rel < 0) first_resp_rel = cyc_n - t0;
        end
        if (arvalid) begin
          ar_cyc++;
          total++;
          if (raddr !== exp_addr) fail("raddr", raddr, exp_addr);
          if (arready) ar_hs++;
        end
        if (awvalid) begin
          aw_cyc++;
          total++;
          if (waddr !== exp_addr) fail("waddr", waddr, exp_addr);
          if (awready) aw_hs++;
        end
        if (wvalid) begin
          w_cyc++;
          total++;
          if (wdata !== exp_wdata) fail("wdata", wdata, exp_wdata);
          total++;
          if (wstrob !== exp_wmask) fail("wstrob", wstrob, exp_wmask);
          if (wready) w_hs++;
        end
        if (p_ar) begin
          total++;
          if (arvalid !== !p_arr) fail("arvalid_hold", arvalid, !p_arr);
        end
        if (p_aw) begin
          total++;
          if (awvalid !== !p_awr) fail("awvalid_hold", awvalid, !p_awr);
        end
        if (p_w) begin
          total++;
          if (wvalid !== !p_wr) fail("wvalid_hold", wvalid, !p_wr);
        end
        p_ar = arvalid; p_arr = arready;
        p_aw = awvalid; p_awr = awready;
        p_w  = wvalid;  p_wr  = wready;
      end else begin
        p_ar = 1'b0; p_arr = 1'b0;
        p_aw = 1'b0; p_awr = 1'b0;
        p_w  = 1'b0; p_wr  = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    logic [8:0] ctl;
    ctl = {req_ready, resp_valid, resp_err, awvalid, wvalid, bready, arvalid, rready, timeout};
    total++;
    if (ctl !== 9'h0) fail({nm, "_ctl"}, ctl, 0);
    total++;
    if (resp_rdata !== 32'h0) fail({nm, "_rdata"}, resp_rdata, 0);
    total++;
    if (waddr !== 32'h0) fail({nm, "_waddr"}, waddr, 0);
    total++;
    if (raddr !== 32'h0) fail({nm, "_raddr"}, raddr, 0);
    total++;
    if (wdata !== 32'h0) fail({nm, "_wdata"}, wdata, 0);
    total++;
    if (wstrob !== 4'h0) fail({nm, "_wstrob"}, wstrob, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (req_ready !== 1'b1) fail("req_ready_wait", req_ready, 1);
  endtask

  task automatic start_txn();
    t0 = cyc_n;
    ar_cyc = 0; aw_cyc = 0; w_cyc = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0;
    resp_cyc = 0; first_resp_rel = -1;
    busy_n = 0; last_busy = 0;
  endtask

  task automatic respond(input int hold);
    for (int i = 0; i < hold; i++) begin
      resp_ready = 1'b0;
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    resp_due = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic [2:0] rr,
                         input int ar_wait, input int hold);
    int k;
    bit ok;
    exp_addr = a; exp_rdata = d; exp_err = (rr != 3'b000);
    wait_idle();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = a;
    req_wdata = $urandom; req_wmask = 4'($urandom);
    start_txn();
    tick();
    req_valid = 1'b0; req_addr = $urandom;
    txn_active = 1'b1;
    k = 0; ok = 0;
    while (!ok && k < 60) begin
      arready = (k >= ar_wait);
      if (arvalid && arready) ok = 1;
      tick();
      k++;
    end
    arready = 1'b0;
    total++;
    if (ok !== 1'b1) fail("ar_handshake_bound", ok, 1);
    rvalid = 1'b1; rdata = d; rresp = rr;
    tick();
    rvalid = 1'b0; rdata = $urandom; rresp = 3'b000;
    txn_active = 1'b0; resp_due = 1'b1;
    respond(hold);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input int aw_wait, input int w_wait, input logic [2:0] br);
    int k;
    bit aw_ok, w_ok;
    exp_addr = a; exp_wdata = d; exp_wmask = m; exp_rdata = 32'h0; exp_err = (br != 3'b000);
    wait_idle();
    req_valid = 1'b1; req_wen = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    start_txn();
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom);
    txn_active = 1'b1;
    k = 0; aw_ok = 0; w_ok = 0;
    while (!(aw_ok && w_ok) && k < 40) begin
      awready = !aw_ok && (k >= aw_wait);
      wready  = !w_ok && (k >= w_wait);
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      tick();
      k++;
    end
    awready = 1'b0; wready = 1'b0;
    total++;
    if ((aw_ok && w_ok) !== 1'b1) fail("aw_w_handshake_bound", aw_ok && w_ok, 1);
    bvalid = 1'b1; bresp = br;
    tick();
    bvalid = 1'b0; bresp = 3'b000;
    txn_active = 1'b0; resp_due = 1'b1;
    respond(0);
  endtask

  initial begin
    rst_n = 1'b0; chk_en = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    resp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_wmask = '0; exp_err = 1'b0;
    exp_timeout = 1'b0; txn_active = 1'b0; resp_due = 1'b0;
    start_txn();

    #3;
    chk_all_zero("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;
    repeat (10) tick();
    total++;
    if (req_ready !== 1'b1) fail("idle_req_ready", req_ready, 1);
    total++;
    if ({arvalid, awvalid, wvalid, rready, bready, resp_valid} !== 6'h0)
      fail("idle_outs", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 0);

    do_load(32'h8000_0004, 32'hDEAD_BEEF, 3'b000, 0, 0);
    total++;
    if (ar_cyc !== 1) fail("load0_ar_cycles", ar_cyc, 1);
    total++;
    if (ar_hs !== 1) fail("load0_ar_hs", ar_hs, 1);
    total++;
    if (first_resp_rel !== 3) fail("load0_resp_cycle", first_resp_rel, 3);
    total++;
    if (resp_cyc !== 1) fail("load0_resp_len", resp_cyc, 1);
    total++;
    if (resp_rdata !== 32'hDEAD_BEEF) fail("load0_rdata_lit", resp_rdata, 32'hDEAD_BEEF);
    total++;
    if (raddr !== 32'h8000_0004) fail("load0_raddr_lit", raddr, 32'h8000_0004);

    do_store(32'h8000_0010, 32'h1234_5678, 4'h3, 3, 0, 3'b000);
    total++;
    if (aw_cyc !== 4) fail("st_aw_cycles", aw_cyc, 4);
    total++;
    if (w_cyc !== 1) fail("st_w_cycles", w_cyc, 1);
    total++;
    if (aw_hs !== 1) fail("st_aw_hs", aw_hs, 1);
    total++;
    if (w_hs !== 1) fail("st_w_hs", w_hs, 1);
    total++;
    if (first_resp_rel !== 6) fail("st_resp_cycle", first_resp_rel, 6);
    total++;
    if (resp_err !== 1'b0) fail("st_err_lit", resp_err, 0);

    do_load(32'h8000_0008, 32'hCAFE_0001, 3'b010, 0, 5);
    total++;
    if (resp_cyc !== 6) fail("lerr_resp_len", resp_cyc, 6);
    total++;
    if (first_resp_rel !== 3) fail("lerr_resp_cycle", first_resp_rel, 3);
    total++;
    if (resp_err !== 1'b1) fail("lerr_err_lit", resp_err, 1);
    total++;
    if (resp_valid !== 1'b0) fail("lerr_dropped", resp_valid, 0);

    do_store(32'h0000_0100, 32'hA5A5_5A5A, 4'hF, 0, 0, 3'b000);
    total++;
    if (first_resp_rel !== 3) fail("st0_resp_cycle", first_resp_rel, 3);
    total++;
    if (aw_cyc !== 1) fail("st0_aw_cycles", aw_cyc, 1);
    total++;
    if (w_hs !== 1) fail("st0_w_hs", w_hs, 1);

    do_store(32'h0000_0204, 32'h0BAD_F00D, 4'h8, 0, 2, 3'b100);
    total++;
    if (w_cyc !== 3) fail("st1_w_cycles", w_cyc, 3);
    total++;
    if (aw_cyc !== 1) fail("st1_aw_cycles", aw_cyc, 1);
    total++;
    if (first_resp_rel !== 5) fail("st1_resp_cycle", first_resp_rel, 5);
    total++;
    if (resp_err !== 1'b1) fail("st1_err_lit", resp_err, 1);
    total++;
    if (resp_rdata !== 32'h0) fail("st1_rdata_lit", resp_rdata, 0);

    exp_addr = 32'h8000_0020;
    wait_idle();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0020;
    start_txn();
    tick();
    req_valid = 1'b0;
    txn_active = 1'b1;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    total++;
    if (rready !== 1'b1) fail("rst_pre_rready", rready, 1);
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midr_reset");
    txn_active = 1'b0; resp_due = 1'b0; exp_timeout = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'h5555_AAAA;
    tick();
    chk_en = 1'b1;
    repeat (8) tick();
    rvalid = 1'b0;
    total++;
    if (resp_cyc !== 0) fail("midr_no_resp", resp_cyc, 0);
    total++;
    if (req_ready !== 1'b1) fail("midr_req_ready", req_ready, 1);

    do_load(32'h8000_0040, 32'h0F0F_F0F0, 3'b000, 20, 0);
    total++;
    if (ar_cyc !== 21) fail("to_ar_cycles", ar_cyc, 21);
    total++;
    if (first_resp_rel !== 23) fail("to_resp_cycle", first_resp_rel, 23);
    total++;
    if (timeout !== TO_EN) fail("to_flag_lit", timeout, TO_EN);
    total++;
    if (resp_rdata !== 32'h0F0F_F0F0) fail("to_rdata_lit", resp_rdata, 32'h0F0F_F0F0);
    repeat (3) tick();
    total++;
    if (timeout !== TO_EN) fail("to_sticky", timeout, TO_EN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
